// File: rtl/squares_pkg.sv
// Shared types, colour table and default 640x480 timing for the squares display path.
package squares_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam logic [23:0] SQ_COLOR [0:7] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
    24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'hFF8000
  };

  localparam int CNT_W        = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_timing.sv
// Raster counters with combinational sync/active decode and frame_start pulse.
module vga_timing
  import squares_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             active,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign hs          = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vs          = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
  assign active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

endmodule

// File: rtl/squares_engine.sv
// Renders N_SQ coloured squares over VGA timing; moves are buffered and applied at frame start.
module squares_engine
  import squares_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int N_SQ     = 4,
  parameter int SIZE     = 32,
  parameter int STEP     = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_sel,
  input  logic [1:0] cmd_dir,
  output logic       vga_HS,
  output logic       vga_VS,
  output logic       vga_BLANK,
  output logic       vga_SYNC,
  output logic [7:0] vga_R,
  output logic [7:0] vga_G,
  output logic [7:0] vga_B,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       frame_start,
  output logic       cmd_dropped
);

  if (N_SQ < 1 || N_SQ > 8) begin : g_bad_nsq
    $error("squares_engine: N_SQ must be in 1..8");
  end
  if (N_SQ * (SIZE + STEP) > H_ACTIVE) begin : g_bad_fit
    $error("squares_engine: N_SQ*(SIZE+STEP) exceeds H_ACTIVE");
  end

  localparam logic [9:0]  STEP_C  = 10'(STEP);
  localparam logic [10:0] SIZE_C  = 11'(SIZE);
  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - SIZE);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - SIZE);
  localparam logic [9:0]  Y_INIT  = 10'((V_ACTIVE - SIZE) / 2);
  localparam logic [3:0]  SEL_LIM = 4'(N_SQ);

  function automatic logic [9:0] sat_dec(input logic [9:0] v);
    logic signed [11:0] d;
    d = signed'({2'b00, v}) - signed'({2'b00, STEP_C});
    return (d < 0) ? 10'd0 : d[9:0];
  endfunction

  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [9:0] lim);
    logic [10:0] s;
    s = {1'b0, v} + {1'b0, STEP_C};
    return (s > {1'b0, lim}) ? lim : s[9:0];
  endfunction

  function automatic logic in_sq(input logic [9:0] h, input logic [9:0] v,
                                 input logic [9:0] x, input logic [9:0] y);
    return ({1'b0, h} >= {1'b0, x}) && ({1'b0, h} < ({1'b0, x} + SIZE_C)) &&
           ({1'b0, v} >= {1'b0, y}) && ({1'b0, v} < ({1'b0, y} + SIZE_C));
  endfunction

  logic [9:0] h_cnt, v_cnt;
  logic       hs_raw, vs_raw, active, fs;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (clk_clk),
    .rst         (reset_reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs          (hs_raw),
    .vs          (vs_raw),
    .active      (active),
    .frame_start (fs)
  );

  logic       hold_vld_q, hold_vld_d;
  logic [2:0] hold_sel_q, hold_sel_d;
  dir_t       hold_dir_q, hold_dir_d;
  logic       dropped_q, dropped_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0] x_q [N_SQ];
  logic [9:0] x_d [N_SQ];
  logic [9:0] y_q [N_SQ];
  logic [9:0] y_d [N_SQ];
  logic [9:0] cur_x, cur_y, nxt_x, nxt_y;

  // Command buffer: load when empty, apply and release only on frame_start.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_sel_d = hold_sel_q;
    hold_dir_d = hold_dir_q;
    dropped_d  = dropped_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    x_d        = x_q;
    y_d        = y_q;
    cur_x      = '0;
    cur_y      = '0;
    for (int i = 0; i < N_SQ; i++) begin
      if (hold_sel_q == 3'(i)) begin
        cur_x = x_q[i];
        cur_y = y_q[i];
      end
    end
    nxt_x = cur_x;
    nxt_y = cur_y;
    case (hold_dir_q)
      UP:      nxt_y = sat_dec(cur_y);
      DOWN:    nxt_y = sat_inc(cur_y, Y_MAX);
      LEFT:    nxt_x = sat_dec(cur_x);
      default: nxt_x = sat_inc(cur_x, X_MAX);
    endcase

    if (hold_vld_q) begin
      if (fs) begin
        hold_vld_d = 1'b0;
        if ({1'b0, hold_sel_q} >= SEL_LIM) begin
          dropped_d = 1'b1;
        end else begin
          pos_x_d = nxt_x;
          pos_y_d = nxt_y;
          for (int i = 0; i < N_SQ; i++) begin
            if (hold_sel_q == 3'(i)) begin
              x_d[i] = nxt_x;
              y_d[i] = nxt_y;
            end
          end
        end
      end
    end else if (cmd_valid) begin
      hold_vld_d = 1'b1;
      hold_sel_d = cmd_sel;
      hold_dir_d = dir_t'(cmd_dir);
    end
  end

  // Pixel mux: iterate high to low so the lowest-index square wins overlaps.
  logic [23:0] hit_rgb;
  always_comb begin
    hit_rgb = '0;
    for (int i = N_SQ - 1; i >= 0; i--) begin
      if (in_sq(h_cnt, v_cnt, x_q[i], y_q[i])) hit_rgb = SQ_COLOR[i];
    end
  end

  logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    hs_d    = hs_raw;
    vs_d    = vs_raw;
    blank_d = active;
    rgb_d   = active ? hit_rgb : 24'd0;
  end

  // Output stage boundary: everything on the vga_* pins is one clock behind the counters.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hold_vld_q <= 1'b0;
      dropped_q  <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      for (int i = 0; i < N_SQ; i++) begin
        x_q[i] <= 10'(i * (SIZE + STEP));
        y_q[i] <= Y_INIT;
      end
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      dropped_q  <= dropped_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_q    <= blank_d;
      rgb_q      <= rgb_d;
    end
    hold_sel_q <= hold_sel_d;
    hold_dir_q <= hold_dir_d;
  end

  assign cmd_ready   = ~hold_vld_q;
  assign frame_start = fs;
  assign cmd_dropped = dropped_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign vga_HS      = hs_q;
  assign vga_VS      = vs_q;
  assign vga_BLANK   = blank_q;
  assign vga_SYNC    = 1'b0;
  assign vga_R       = rgb_q[23:16];
  assign vga_G       = rgb_q[15:8];
  assign vga_B       = rgb_q[7:0];

endmodule

// File: tb/tb_squares_engine.sv
// Directed bench for squares_engine on a reduced 72x37 raster with 8-pixel squares.
module tb_squares_engine;
  import squares_pkg::*;

  localparam int HT    = 72;
  localparam int VT    = 37;
  localparam int FRAME = HT * VT;
  localparam int FS    = 32 * HT;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_sel;
  logic [1:0] cmd_dir;
  logic       vga_HS, vga_VS, vga_BLANK, vga_SYNC;
  logic [7:0] vga_R, vga_G, vga_B;
  logic [9:0] pos_x, pos_y;
  logic       frame_start, cmd_dropped;

  always #5 clk = ~clk;

  squares_engine #(
    .H_ACTIVE (64), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACTIVE (32), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b0), .N_SQ (4), .SIZE (8), .STEP (8)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sel     (cmd_sel),
    .cmd_dir     (cmd_dir),
    .vga_HS      (vga_HS),
    .vga_VS      (vga_VS),
    .vga_BLANK   (vga_BLANK),
    .vga_SYNC    (vga_SYNC),
    .vga_R       (vga_R),
    .vga_G       (vga_G),
    .vga_B       (vga_B),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .frame_start (frame_start),
    .cmd_dropped (cmd_dropped)
  );

  // Raster position the DUT counters should hold, tracked independently.
  int tcnt = 0;
  always @(posedge clk) begin
    if (reset) tcnt <= 0;
    else       tcnt <= tcnt + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input int target, input string tag);
    int n = 0;
    while ((tcnt % FRAME) != target && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((tcnt % FRAME) != target) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=%0d", tag, tcnt % FRAME, target);
    end
  endtask

  task automatic px(input int h, input int v, input logic [23:0] exp, input string tag);
    wait_pos(v * HT + h + 1, tag);
    chk(tag, {8'h00, vga_R, vga_G, vga_B}, {8'h00, exp});
  endtask

  task automatic wait_apply();
    wait_pos(FS + 1, "apply");
  endtask

  task automatic send_cmd(input logic [2:0] sel, input dir_t dir, output int acc_pos);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_dir   = dir;
    while (!cmd_ready && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%0d expected=%0d", cmd_ready, 1);
    end
    acc_pos = tcnt % FRAME;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_hs"},    vga_HS,      1);
    chk({pfx, "_vs"},    vga_VS,      1);
    chk({pfx, "_blank"}, vga_BLANK,   0);
    chk({pfx, "_rgb"},   {vga_R, vga_G, vga_B}, 0);
    chk({pfx, "_ready"}, cmd_ready,   1);
    chk({pfx, "_fs"},    frame_start, 0);
    chk({pfx, "_drop"},  cmd_dropped, 0);
    chk({pfx, "_posx"},  pos_x,       0);
    chk({pfx, "_posy"},  pos_y,       0);
  endtask

  initial begin
    int hs_lo, vs_lo, blank_hi, rgb_blank, a1, a2;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_sel   = '0;
    cmd_dir   = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_sync", vga_SYNC, 0);
    reset = 1'b0;

    // One full frame of sync/blank statistics.
    hs_lo = 0; vs_lo = 0; blank_hi = 0; rgb_blank = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (!vga_HS) hs_lo++;
      if (!vga_VS) vs_lo++;
      if (vga_BLANK) blank_hi++;
      if (!vga_BLANK && {vga_R, vga_G, vga_B} != 0) rgb_blank++;
    end
    chk("hs_low_cnt",    hs_lo,     4 * VT);
    chk("vs_low_cnt",    vs_lo,     2 * HT);
    chk("blank_hi_cnt",  blank_hi,  64 * 32);
    chk("rgb_in_blank",  rgb_blank, 0);

    wait_pos(FS, "fs");
    chk("fs_pulse", frame_start, 1);
    @(negedge clk);
    chk("fs_after", frame_start, 0);

    // Initial render, then a move issued mid-frame that must not show until next frame.
    px(0, 12, 24'hFF0000, "init_sq0_tl");
    px(8, 12, 24'h000000, "init_gap");
    px(10, 12, 24'h000000, "init_gap2");
    chk("init_blank_hi", vga_BLANK, 1);
    px(16, 12, 24'h00FF00, "init_sq1");
    send_cmd(3'd1, RIGHT, a1);
    chk("held_ready_low", cmd_ready, 0);
    px(16, 15, 24'h00FF00, "defer_old_sq1");
    px(26, 15, 24'h000000, "defer_old_gap");
    px(7, 19, 24'hFF0000, "init_sq0_br");
    px(48, 19, 24'hFFFF00, "init_sq3");
    px(0, 20, 24'h000000, "init_below");
    wait_apply();
    chk("move_ready_back", cmd_ready, 1);
    chk("move_posx", pos_x, 24);
    chk("move_posy", pos_y, 12);
    px(16, 15, 24'h000000, "moved_gap");
    px(26, 15, 24'h00FF00, "moved_sq1");

    // Saturation on the left and right edges.
    send_cmd(3'd0, LEFT, a1);
    wait_apply();
    chk("left_sat_x", pos_x, 0);
    chk("left_sat_y", pos_y, 12);
    for (int k = 0; k < 8; k++) begin
      send_cmd(3'd0, RIGHT, a1);
      wait_apply();
    end
    chk("right_sat_x", pos_x, 56);
    px(0, 12, 24'h000000, "sq0_left_gone");
    px(56, 12, 24'hFF0000, "sq0_at_right");

    // Square 3 onto square 0: the lower index must win.
    send_cmd(3'd3, RIGHT, a1);
    wait_apply();
    chk("ovl_posx", pos_x, 56);
    px(52, 15, 24'h000000, "ovl_vacated");
    px(60, 15, 24'hFF0000, "ovl_red");

    // Two commands in one frame: the second waits until the cycle after frame_start.
    send_cmd(3'd2, DOWN, a1);
    send_cmd(3'd2, DOWN, a2);
    chk("bp_accept_pos", a2, FS + 1);
    chk("bp_first_y", pos_y, 20);
    chk("bp_first_x", pos_x, 32);
    wait_apply();
    chk("bp_second_y", pos_y, 24);
    px(32, 24, 24'h0000FF, "down_sat_sq2");

    send_cmd(3'd5, UP, a1);
    wait_apply();
    chk("drop_flag", cmd_dropped, 1);
    chk("drop_posx", pos_x, 32);
    chk("drop_posy", pos_y, 24);

    // Reset at (30,10) with a command still pending.
    wait_pos(10 * HT + 29, "pre_rst");
    send_cmd(3'd0, RIGHT, a1);
    chk("pend_ready_low", cmd_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    px(0, 12, 24'hFF0000, "post_sq0");
    px(16, 12, 24'h00FF00, "post_sq1");
    px(56, 12, 24'h000000, "post_right_empty");
    wait_apply();
    chk("no_pending_x", pos_x, 0);
    chk("no_pending_ready", cmd_ready, 1);
    px(0, 12, 24'hFF0000, "no_pending_sq0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/squares_engine.md
# squares_engine

Parametrised successor of the fixed squares demo datapath. It generates VGA raster timing for a configurable mode and renders N_SQ solid coloured squares on a black background. Square moves arrive as one-hot-free commands on a valid/ready port, typically from the PS/2 decode stage. Moves are applied only at frame start, so the picture never tears. The last moved square's position is exported for the hex/LED display logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 0, asserted level of vga_HS/vga_VS
- N_SQ, 4, number of squares (1..8)
- SIZE, 32, square edge in pixels
- STEP, 8, pixels moved per command
- clk_clk  in  1  pixel clock
- reset_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  move command present
- cmd_ready  out  1  command holding register empty
- cmd_sel  in  3  square index
- cmd_dir  in  2  0=up, 1=down, 2=left, 3=right
- vga_HS, vga_VS  out  1 each  syncs
- vga_BLANK  out  1  active-low blank (1 = active video)
- vga_SYNC  out  1  tied 0
- vga_R, vga_G, vga_B  out  8 each  pixel colour
- pos_x, pos_y  out  10 each  position of last moved square
- frame_start  out  1  one-cycle pulse at h=0, v=V_ACTIVE
- cmd_dropped  out  1  sticky; set when cmd_sel >= N_SQ

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined analogously.
- h_cnt wraps at H_TOTAL-1. v_cnt increments on h wrap and wraps at V_TOTAL-1.
- HS is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS uses the same rule in lines on v.
- Active video is h<H_ACTIVE and v<V_ACTIVE.
- Per-square registers x[i], y[i] are 10-bit unsigned.
  - Reset value: x = i*(SIZE+STEP), y = (V_ACTIVE-SIZE)/2.
  - Requirement: N_SQ*(SIZE+STEP) <= H_ACTIVE. This is checked by elaboration assertion.
- Command holding register, one entry:
  - A command is accepted when cmd_valid & cmd_ready. cmd_ready then drops to 0.
  - The held command is applied on the frame_start cycle. cmd_ready returns to 1 on the next cycle.
  - A command with sel >= N_SQ is accepted and discarded at frame_start. It sets cmd_dropped, and pos_x/pos_y are unchanged.
- Move arithmetic saturates:
  - left: x = (x<STEP) ? 0 : x-STEP
  - right: x = min(x+STEP, H_ACTIVE-SIZE)
  - up and down follow the same rules in y against V_ACTIVE-SIZE.
- pos_x/pos_y take the post-move position of the applied square. Reset value is 0.
- Pixel (h,v) is inside square i iff x[i] <= h < x[i]+SIZE and y[i] <= v < y[i]+SIZE.
- Overlap: the lowest index wins.
- Colour comes from the package table SQ_COLOR[i]. Outside all squares the colour is 0. During blank RGB is 0.

## Timing
- One pipeline stage: counters and hit detection are combinational, and all vga_* outputs are registered. Outputs for counter value (h,v) appear one cycle later.
- Reset values:
  - h_cnt = v_cnt = 0
  - vga_HS = vga_VS = ~SYNC_POL
  - vga_BLANK = 0, RGB = 0
  - cmd_ready = 1, frame_start = 0, cmd_dropped = 0
  - holding register empty
- Reset asserted mid-frame: counters, positions and outputs return to reset values, and any pending command is dropped. Reset outranks frame_start and command acceptance.
- cmd_valid during the frame_start cycle while holding is empty: the command is accepted and waits for the next frame_start.
- cmd_ready is asserted for exactly 1 cycle minimum between frames when a stream of commands is waiting.

## Structure
- Package squares_pkg holds:
  - dir_t enum (UP, DOWN, LEFT, RIGHT)
  - SQ_COLOR[0:7] 24-bit table: red, green, blue, yellow, cyan, magenta, white, orange
  - the default 640x480 timing constants
- Sub-module vga_timing contains the counters, sync/blank decode and frame_start. It is parametrised by the timing parameters and reused by later display blocks.
- The square registers, command buffer and pixel mux stay in squares_engine.

## Test plan
- Sync check, defaults, after reset: HS low 96 of every 800 clocks. VS low 1600 of every 420000 clocks. BLANK high 640 clocks per visible line. No RGB != 0 while BLANK = 0.
- Initial render: pixel (0,224) = FF0000, (31,255) = FF0000, (32,224) = 000000, (40,224) = 00FF00.
- Deferred move: issue sel=1, dir=right mid-frame. Raster is unchanged for the remainder of the frame. Next frame (48,224) = 00FF00 and (40,224) = 000000. pos_x = 48, pos_y = 224.
- Saturation and overlap:
  - sel=0 left → x stays 0.
  - sel=0 right 80 times → x = 608.
  - Move sel=1 onto sel=0 → overlap pixels are red.
- Backpressure and invalid select:
  - Two commands in one frame: the second sees cmd_ready = 0 until the cycle after frame_start and is applied one frame later.
  - sel = 5 with N_SQ = 4 → cmd_dropped = 1, positions unchanged.
- Reset mid-line (h = 300, v = 100) with a pending command: outputs take reset values the next cycle. The post-reset frame shows initial positions. The pending command is never applied.
